// File: rtl/acondicionador_entradas_pkg.sv
// Shared constants for the input-conditioning stage: channel map, default
// timing parameters and the debounce FSM state encoding.
package acondicionador_entradas_pkg;

  localparam int unsigned CH_SENSOR_A = 0;
  localparam int unsigned CH_SENSOR_B = 1;
  localparam int unsigned CH_PASO_A   = 2;
  localparam int unsigned CH_PASO_B   = 3;
  localparam int unsigned NUM_CH      = 4;

  localparam int unsigned SAMPLE_DIV_DEF = 50000;
  localparam int unsigned STABLE_N_DEF   = 10;

  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_CHANGING = 1'b1;

endpackage

// File: rtl/acondicionador_entradas_debounce_canal.sv
// One conditioning channel: two-flop synchroniser followed by a tick-driven
// debounce FSM. rise_c flags the edge at which the debounced level goes 0->1.
module debounce_canal
  import acondicionador_entradas_pkg::*;
#(
  parameter int unsigned STABLE_N = STABLE_N_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic sample_tick,
  output logic level,
  output logic rise_c
);

  localparam int unsigned CW = (STABLE_N > 1) ? $clog2(STABLE_N) : 1;

  logic          sync1;
  logic          sync2;
  logic [0:0]    state;
  logic [0:0]    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          level_nx;

  // Metastability guard on the raw switch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_STABLE;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      level <= level_nx;
    end
  end

  // Level only flips after STABLE_N consecutive ticks that disagree with it
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    level_nx = level;
    if (sample_tick) begin
      case (state)
        ST_STABLE: begin
          if (sync2 != level) begin
            state_nx = ST_CHANGING;
            cnt_nx   = CW'(1);
          end
        end
        ST_CHANGING: begin
          if (sync2 == level) begin
            state_nx = ST_STABLE;
            cnt_nx   = '0;
          end else if (cnt == CW'(STABLE_N - 1)) begin
            level_nx = ~level;
            state_nx = ST_STABLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign rise_c = level_nx & ~level;

endmodule

// File: rtl/acondicionador_entradas.sv
// Conditions the four traffic-light switches: shared sample prescaler, four
// debounce channels, and sticky crossing requests cleared by controller acks.
module acondicionador_entradas
  import acondicionador_entradas_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int unsigned STABLE_N   = STABLE_N_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_a_in,
  input  logic sensor_b_in,
  input  logic paso_a_in,
  input  logic paso_b_in,
  input  logic paso_a_ack,
  input  logic paso_b_ack,
  output logic sensor_a,
  output logic sensor_b,
  output logic paso_a_req,
  output logic paso_b_req
);

  localparam int unsigned PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [PW-1:0]     pre;
  logic              tick_c;
  logic [NUM_CH-1:0] raw_in;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] rise_c;
  logic              unused_rise;

  assign tick_c = (pre == PW'(SAMPLE_DIV - 1));

  // Free-running sample prescaler shared by every channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (tick_c) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  assign raw_in[CH_SENSOR_A] = sensor_a_in;
  assign raw_in[CH_SENSOR_B] = sensor_b_in;
  assign raw_in[CH_PASO_A]   = paso_a_in;
  assign raw_in[CH_PASO_B]   = paso_b_in;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_canal
    debounce_canal #(
      .STABLE_N (STABLE_N)
    ) u_canal (
      .clk         (clk),
      .rst         (rst),
      .raw         (raw_in[g]),
      .sample_tick (tick_c),
      .level       (level[g]),
      .rise_c      (rise_c[g])
    );
  end

  assign sensor_a    = level[CH_SENSOR_A];
  assign sensor_b    = level[CH_SENSOR_B];
  assign unused_rise = rise_c[CH_SENSOR_A] | rise_c[CH_SENSOR_B];

  // A fresh press beats a coincident ack so no request is ever dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paso_a_req <= 1'b0;
      paso_b_req <= 1'b0;
    end else begin
      if (rise_c[CH_PASO_A]) begin
        paso_a_req <= 1'b1;
      end else if (paso_a_ack) begin
        paso_a_req <= 1'b0;
      end
      if (rise_c[CH_PASO_B]) begin
        paso_b_req <= 1'b1;
      end else if (paso_b_ack) begin
        paso_b_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acondicionador_entradas.sv
// Scoreboard bench: stimulus queues expected output transitions with cycle
// windows; a monitor matches every observed output change against them.
module tb_acondicionador_entradas;

  localparam int unsigned SD = 4;
  localparam int unsigned SN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sensor_a_in = 1'b0, sensor_b_in = 1'b0, paso_a_in = 1'b0, paso_b_in = 1'b0;
  logic paso_a_ack = 1'b0, paso_b_ack = 1'b0;
  logic sensor_a, sensor_b, paso_a_req, paso_b_req;

  acondicionador_entradas #(
    .SAMPLE_DIV (SD),
    .STABLE_N   (SN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sensor_a_in (sensor_a_in),
    .sensor_b_in (sensor_b_in),
    .paso_a_in   (paso_a_in),
    .paso_b_in   (paso_b_in),
    .paso_a_ack  (paso_a_ack),
    .paso_b_ack  (paso_b_ack),
    .sensor_a    (sensor_a),
    .sensor_b    (sensor_b),
    .paso_a_req  (paso_a_req),
    .paso_b_req  (paso_b_req)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   ch;
    logic val;
    int   lo;
    int   hi;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [3:0] outs;
  logic [3:0] prev = 4'b0;
  int   idx;

  assign outs = {paso_b_req, paso_a_req, sensor_b, sensor_a};

  task automatic push(input int ch, input logic v, input int lo, input int hi);
    exp_t e;
    e.ch = ch; e.val = v; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: every output change must match the oldest pending expectation
  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < 4; c++) begin
        if (outs[c] !== prev[c]) begin
          idx = -1;
          for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].ch == c) begin
              idx = i;
              break;
            end
          end
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL unexpected ch%0d: got %b at cycle %0d, required no change", c, outs[c], cyc);
          end else begin
            if (outs[c] !== sb[idx].val || cyc < sb[idx].lo || cyc > sb[idx].hi) begin
              errors++;
              $display("FAIL event ch%0d: got %b at cycle %0d, required %b in cycles %0d..%0d",
                       c, outs[c], cyc, sb[idx].val, sb[idx].lo, sb[idx].hi);
            end
            sb.delete(idx);
          end
        end
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].hi < cyc) begin
          checks++;
          errors++;
          $display("FAIL missed ch%0d: got no change by cycle %0d, required %b in cycles %0d..%0d",
                   sb[i].ch, cyc, sb[i].val, sb[i].lo, sb[i].hi);
          sb.delete(i);
        end
      end
    end
    prev = outs;
  end

  int k, r, t1, f;

  initial begin
    step(3);
    chk("rst0 sensor_a", sensor_a, 1'b0);
    chk("rst0 sensor_b", sensor_b, 1'b0);
    chk("rst0 paso_a_req", paso_a_req, 1'b0);
    chk("rst0 paso_b_req", paso_b_req, 1'b0);
    rst = 1'b0;
    mon_en = 1'b1;

    // 1: reach paso_a_req=1 and sensor_b=1, then reset asynchronously
    sensor_b_in = 1'b1; paso_a_in = 1'b1; k = cyc;
    push(1, 1'b1, k + 11, k + 14);
    push(2, 1'b1, k + 11, k + 14);
    step(16);
    chk("t1 pre sensor_b", sensor_b, 1'b1);
    chk("t1 pre paso_a_req", paso_a_req, 1'b1);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t1 async sensor_a", sensor_a, 1'b0);
    chk("t1 async sensor_b", sensor_b, 1'b0);
    chk("t1 async paso_a_req", paso_a_req, 1'b0);
    chk("t1 async paso_b_req", paso_b_req, 1'b0);
    sensor_b_in = 1'b0; paso_a_in = 1'b0;
    step(3);
    chk("t1 held sensor_b", sensor_b, 1'b0);
    chk("t1 held paso_a_req", paso_a_req, 1'b0);
    rst = 1'b0; r = cyc;
    mon_en = 1'b1;
    step(4);

    // 2: clean press and release on sensor_a
    sensor_a_in = 1'b1; k = cyc;
    push(0, 1'b1, k + 11, k + 14);
    step(40);
    sensor_a_in = 1'b0; k = cyc;
    push(0, 1'b0, k + 11, k + 14);
    step(40);

    // 3: 5-cycle glitch on paso_a must never surface
    paso_a_in = 1'b1;
    step(5);
    paso_a_in = 1'b0;
    step(30);
    chk("t3 glitch paso_a_req", paso_a_req, 1'b0);

    // 4: bounce on paso_b, then a steady hold
    for (int i = 0; i < 10; i++) begin
      paso_b_in = ~paso_b_in;
      step(3);
    end
    paso_b_in = 1'b1; k = cyc;
    push(3, 1'b1, k + 1, k + 14);
    step(30);

    // 5: ack while held, no re-arm, then fresh press
    paso_a_in = 1'b1; k = cyc;
    push(2, 1'b1, k + 11, k + 14);
    step(20);
    paso_a_ack = 1'b1; k = cyc;
    push(2, 1'b0, k + 1, k + 1);
    step(1);
    paso_a_ack = 1'b0;
    step(20);
    chk("t5 held no rearm", paso_a_req, 1'b0);
    paso_a_in = 1'b0;
    step(20);
    paso_a_in = 1'b1; k = cyc;
    push(2, 1'b1, k + 11, k + 14);
    step(20);
    chk("t5 rearm paso_a_req", paso_a_req, 1'b1);

    // 6: clear paso_b, idle ack, then ack coincident with a debounced rise
    paso_b_in = 1'b0;
    step(20);
    paso_b_ack = 1'b1; k = cyc;
    push(3, 1'b0, k + 1, k + 1);
    step(1);
    paso_b_ack = 1'b0;
    step(4);
    paso_b_ack = 1'b1;
    step(1);
    paso_b_ack = 1'b0;
    step(2);
    chk("t6 idle ack paso_b_req", paso_b_req, 1'b0);
    paso_b_in = 1'b1; k = cyc;
    t1 = k + 3;
    while ((t1 - r) % SD != 0) t1++;
    f = t1 + (SN - 1) * SD;
    push(3, 1'b1, f, f);
    while (cyc < f - 1) step(1);
    paso_b_ack = 1'b1;
    step(1);
    paso_b_ack = 1'b0;
    step(1);
    chk("t6 collision paso_b_req", paso_b_req, 1'b1);
    step(10);
    chk("t6 collision hold", paso_b_req, 1'b1);

    step(5);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acondicionador_entradas.md
Name: acondicionador_entradas

Overview:
Input-conditioning stage that sits directly upstream of the traffic-light controller. It takes the four raw slide-switch inputs: car presence on A and B (SensorA, SensorB), and crossing requests on A and B (PasoA, PasoB). It synchronises and debounces all four. It also turns each crossing press into a sticky request that holds until the controller acknowledges it. The controller consumes the clean sensor levels and the request flags instead of raw switches.

Parameters:
SAMPLE_DIV, 50000, clk cycles per debounce sample tick (1 ms at 50 MHz); legal range >= 2
STABLE_N, 10, consecutive sample ticks an input must differ from its debounced level before that level flips; legal range >= 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
sensor_a_in  input  1  raw switch, cars present on A
sensor_b_in  input  1  raw switch, cars present on B
paso_a_in  input  1  raw switch, crossing request on A
paso_b_in  input  1  raw switch, crossing request on B
paso_a_ack  input  1  one-cycle pulse from controller: request A served
paso_b_ack  input  1  one-cycle pulse from controller: request B served
sensor_a  output  1  debounced level of sensor_a_in
sensor_b  output  1  debounced level of sensor_b_in
paso_a_req  output  1  sticky crossing request A
paso_b_req  output  1  sticky crossing request B

Behaviour:
- Reset: rst is asynchronous and active-high. While rst is high, all of the following are 0: synchroniser flops, prescaler, per-channel counters, debounced levels, sensor_a, sensor_b, paso_a_req, paso_b_req. A reset asserted mid-debounce or with a request pending clears everything immediately. No request survives reset.
- Synchroniser: every raw input passes through two flops. "synced" below means the second flop.
- Prescaler:
  - Counter runs 0..SAMPLE_DIV-1 and wraps.
  - sample_tick is high for exactly the one cycle in which the counter equals SAMPLE_DIV-1.
  - One prescaler is shared by all channels.
- Per-channel debounce FSM, two states, with a counter cnt of width clog2(STABLE_N):
  - STABLE:
    - On sample_tick with synced != level: go to CHANGING, cnt = 1.
    - If STABLE_N-1 == 0 this would flip immediately; that case is excluded by STABLE_N >= 2.
  - CHANGING:
    - On sample_tick with synced == level: go to STABLE, cnt = 0. This rejects the glitch.
    - On sample_tick with synced != level and cnt == STABLE_N-1: invert level, go to STABLE, cnt = 0.
    - On sample_tick with synced != level otherwise: cnt++.
  - Between ticks, state and cnt hold.
- Consequences of the FSM:
  - level flips at the clock edge of the STABLE_N-th consecutive differing tick.
  - Any pulse lasting fewer than STABLE_N-1 full tick periods never reaches the output.
- Sensor outputs: sensor_a and sensor_b are the registered debounced levels directly. They carry no further latency.
- Request latches, for paso_x_req:
  - Set: at the same edge where the debounced paso_x level goes 0→1.
  - Clear: at the edge where paso_x_ack = 1.
  - Set and ack in the same cycle: set wins and req stays 1, so a new press is never lost.
  - Ack while req = 0: no effect.
  - After an ack, a switch still held does not re-arm the request. Only a fresh debounced rising edge sets it again.
  - A debounced falling edge does not clear req.
- Latency: from a raw edge to a debounced output change = 2 sync cycles + STABLE_N tick boundaries. The bounds are 2+(STABLE_N-1)*SAMPLE_DIV+1 to 2+STABLE_N*SAMPLE_DIV cycles.
- Channels are fully independent. Simultaneous events on several channels are handled in parallel.

Decomposition:
- Shared package holds:
  - channel indices CH_SENSOR_A=0, CH_SENSOR_B=1, CH_PASO_A=2, CH_PASO_B=3, and NUM_CH=4
  - default SAMPLE_DIV and STABLE_N values
  - debounce FSM state encoding (ST_STABLE=0, ST_CHANGING=1)
- One sub-module, debounce_canal: synchroniser, FSM and counter for one channel. It takes sample_tick as an input and is instantiated four times.
- The top level holds the prescaler and the two request latches.

Test Plan:
All scenarios use SAMPLE_DIV=4 and STABLE_N=3.
1. Reset: get paso_a_req=1 and sensor_b=1, then assert rst asynchronously between clock edges → all four outputs read 0 before the next edge and stay 0 until release.
2. Clean press: raise sensor_a_in and hold for 40 cycles → sensor_a rises exactly once, between 11 and 14 cycles after the raw edge. Then drop the input and hold → sensor_a falls within the same window.
3. Glitch rejection: pulse paso_a_in high for 5 cycles → paso_a_req and the debounced paso_a level stay 0 for the next 30 cycles.
4. Bounce: toggle paso_b_in every 3 cycles for 30 cycles, then hold it high → paso_b_req rises exactly once, only after the hold begins, and no extra rises occur.
5. Ack and re-arm: with paso_a_req=1, pulse paso_a_ack for 1 cycle while the switch is held → req is 0 on the next edge and stays 0. Release for ≥16 cycles and press again → req is 1 within the latency window.
6. Collision: align a paso_b_ack pulse with the cycle of a debounced paso_b rising edge → paso_b_req is 1 afterwards. Separately, ack while req=0 → req stays 0.
